// File: rtl/tile_sched_pkg.sv
// Shared types and constants for the tile scheduler: FSM state encoding,
// default watchdog limit and the tile-counter width helper.
package tile_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT,
        DONE
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    // Counter must hold every value 0..max_tiles inclusive.
    function automatic int unsigned tile_width(input int unsigned max_tiles);
        return $clog2(max_tiles + 1);
    endfunction

endpackage

// File: rtl/tile_scheduler_if.sv
// Host/control-unit bundle for tile_scheduler. master = job issuer plus
// control-unit side stimulus, slave = the scheduler itself.
interface tile_scheduler_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned TILE_W = 5
);
    logic              start;
    logic [TILE_W-1:0] num_tiles;
    logic              abort;
    logic              cu_ready;
    logic              cu_enable;
    logic [ADDR_W-1:0] cu_base_addr;
    logic [TILE_W-1:0] tile_idx;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, num_tiles, abort, cu_ready,
        input  cu_enable, cu_base_addr, tile_idx, busy, done, error
    );

    modport slave (
        input  start, num_tiles, abort, cu_ready,
        output cu_enable, cu_base_addr, tile_idx, busy, done, error
    );
endinterface

// File: rtl/tile_watchdog.sv
// Cycle counter used to bound the time spent waiting on the control unit.
// expired_c rises on the TIMEOUT-th enabled cycle since the last clear.
module tile_watchdog
    import tile_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !expired_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/tile_scheduler.sv
// Tile-level sequencer in front of control_unit: one cu_enable per tile,
// stride the BRAM base between tiles, pulse done at the end.
// Optional WAIT watchdog enabled by `define TILE_SCHED_TIMEOUT_EN.
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int unsigned BRAM_DEPTH = 2,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned MAX_TILES  = 16,
    parameter int unsigned TILE_W     = tile_width(MAX_TILES)
`ifdef TILE_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
`endif
) (
    input logic             clk,
    input logic             reset,
    tile_scheduler_if.slave bus
);
    localparam logic [TILE_W-1:0] MAX_T  = TILE_W'(MAX_TILES);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BRAM_DEPTH);

    state_t            state_q, state_n;
    logic [TILE_W-1:0] count_q, count_n;
    logic [TILE_W-1:0] clamp_c;
    logic [TILE_W-1:0] tile_idx_n;
    logic [ADDR_W-1:0] base_n;
    logic              cu_enable_n, busy_n, done_n, error_n;
    logic              last_tile_c;

`ifdef TILE_SCHED_TIMEOUT_EN
    logic timeout_c;

    tile_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q != WAIT),
        .enable    (state_q == WAIT),
        .expired_c (timeout_c)
    );
`endif

    assign clamp_c     = (bus.num_tiles > MAX_T) ? MAX_T : bus.num_tiles;
    assign last_tile_c = (bus.tile_idx == count_q - TILE_W'(1));

    // Next state and next values of every registered output.
    always_comb begin
        state_n    = state_q;
        count_n    = count_q;
        tile_idx_n = bus.tile_idx;
        base_n     = bus.cu_base_addr;
        error_n    = bus.error;

        if (bus.abort && state_q != IDLE) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        error_n = 1'b0;
                        if (clamp_c == '0) begin
                            state_n = DONE;
                        end else begin
                            count_n    = clamp_c;
                            tile_idx_n = '0;
                            base_n     = '0;
                            state_n    = ISSUE;
                        end
                    end
                end
                ISSUE: state_n = WAIT;
                WAIT: begin
                    if (bus.cu_ready) begin
                        state_n = last_tile_c ? DONE : NEXT;
                    end
`ifdef TILE_SCHED_TIMEOUT_EN
                    else if (timeout_c) begin
                        state_n = IDLE;
                        error_n = 1'b1;
                    end
`endif
                end
                NEXT: begin
                    tile_idx_n = bus.tile_idx + TILE_W'(1);
                    base_n     = bus.cu_base_addr + STRIDE;
                    state_n    = ISSUE;
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        // Outputs are registered images of the state being entered.
        cu_enable_n = (state_n == ISSUE);
        busy_n      = (state_n != IDLE);
        done_n      = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            count_q          <= '0;
            bus.tile_idx     <= '0;
            bus.cu_base_addr <= '0;
            bus.cu_enable    <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.error        <= 1'b0;
        end else begin
            state_q          <= state_n;
            count_q          <= count_n;
            bus.tile_idx     <= tile_idx_n;
            bus.cu_base_addr <= base_n;
            bus.cu_enable    <= cu_enable_n;
            bus.busy         <= busy_n;
            bus.done         <= done_n;
            bus.error        <= error_n;
        end
    end

endmodule
